// File: rtl/ws2812_pixel_stream_encoder.sv
// WS2812 pixel stream encoder: valid/ready pixel words in, RZ line out.
// One-entry skid buffer feeds the shifter for gapless pixels; auto latch.
module ws2812_pixel_stream_encoder #(
    parameter int CLK_FREQ_KHZ   = 50000,
    parameter int BITS_PER_PIXEL = 24,
    parameter int T_HI_TRUE_NS   = 700,
    parameter int T_HI_FALSE_NS  = 300,
    parameter int T_PERIOD_NS    = 1100,
    parameter int T_RESET_NS     = 80000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [BITS_PER_PIXEL-1:0] s_data,
    input  logic                      s_valid,
    input  logic                      s_last,
    output logic                      s_ready,
    output logic                      dout,
    output logic                      busy,
    output logic                      frame_done,
    output logic                      underrun
);

    localparam longint KHZ = longint'(CLK_FREQ_KHZ);
    localparam int HI1_T = int'((longint'(T_HI_TRUE_NS) * KHZ) / 64'd1000000);
    localparam int HI0_T = int'((longint'(T_HI_FALSE_NS) * KHZ) / 64'd1000000);
    localparam int PER_T = int'((longint'(T_PERIOD_NS) * KHZ) / 64'd1000000);
    localparam int RST_T = int'((longint'(T_RESET_NS) * KHZ) / 64'd1000000);
    localparam int MAX_T = (PER_T > RST_T) ? PER_T : RST_T;
    localparam int CW    = $clog2(MAX_T + 1);
    localparam int BW    = BITS_PER_PIXEL;
    localparam int BCW   = (BW > 1) ? $clog2(BW) : 1;

    localparam logic [CW-1:0]  HI1     = CW'(HI1_T);
    localparam logic [CW-1:0]  HI0     = CW'(HI0_T);
    localparam logic [CW-1:0]  PER_M1  = CW'(PER_T - 1);
    localparam logic [CW-1:0]  RST_M1  = CW'(RST_T - 1);
    localparam logic [BCW-1:0] BIT_TOP = BCW'(BW - 1);

    generate
        if (!(BW >= 1 && HI0_T > 0 && HI0_T < HI1_T &&
              HI1_T < PER_T && RST_T >= 1)) begin : g_bad_cfg
            $error("ws2812_pixel_stream_encoder: invalid timing/width");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TX    = 2'd1,
        S_RESET = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [BCW-1:0] bit_cnt, bit_cnt_nxt;
    logic [BW-1:0]  sh, sh_nxt;
    logic           sh_last, sh_last_nxt;
    logic [BW-1:0]  buf_data;
    logic           buf_last;
    logic           buf_full, buf_full_nxt;
    logic           load_buf;
    logic           accept;
    logic           dout_nxt;
    logic           frame_done_nxt;
    logic           underrun_nxt;

    assign accept = s_valid & s_ready;
    assign busy   = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state, counter, shifter and registered-output decode.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        bit_cnt_nxt    = bit_cnt;
        sh_nxt         = sh;
        sh_last_nxt    = sh_last;
        load_buf       = 1'b0;
        dout_nxt       = 1'b0;
        frame_done_nxt = 1'b0;
        underrun_nxt   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (buf_full) begin
                    load_buf  = 1'b1;
                    state_nxt = S_TX;
                end
            end
            S_TX: begin
                dout_nxt = (cnt < (sh[BW-1] ? HI1 : HI0));
                if (cnt == PER_M1) begin
                    if (bit_cnt != '0) begin
                        sh_nxt      = sh << 1;
                        bit_cnt_nxt = bit_cnt - BCW'(1);
                        cnt_nxt     = '0;
                    end else if (sh_last) begin
                        state_nxt = S_RESET;
                        cnt_nxt   = '0;
                    end else if (buf_full) begin
                        load_buf = 1'b1;
                    end else begin
                        underrun_nxt = 1'b1;
                        state_nxt    = S_RESET;
                        cnt_nxt      = '0;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_RESET: begin
                if (cnt == RST_M1) begin
                    state_nxt      = S_IDLE;
                    cnt_nxt        = '0;
                    frame_done_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (load_buf) begin
            sh_nxt      = buf_data;
            sh_last_nxt = buf_last;
            bit_cnt_nxt = BIT_TOP;
            cnt_nxt     = '0;
        end
        buf_full_nxt = (buf_full & ~load_buf) | accept;
    end

    // Datapath: counters, shifter, skid buffer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            bit_cnt    <= '0;
            sh         <= '0;
            sh_last    <= 1'b0;
            buf_data   <= '0;
            buf_last   <= 1'b0;
            buf_full   <= 1'b0;
            s_ready    <= 1'b0;
            dout       <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            sh         <= sh_nxt;
            sh_last    <= sh_last_nxt;
            buf_full   <= buf_full_nxt;
            s_ready    <= ~buf_full_nxt;
            dout       <= dout_nxt;
            frame_done <= frame_done_nxt;
            underrun   <= underrun_nxt;
            if (accept) begin
                buf_data <= s_data;
                buf_last <= s_last;
            end
        end
    end

endmodule
